// File: rtl/image_frame_buffer_pkg.sv
// image_frame_buffer_pkg: writer states, lane ratio and read latency for the frame buffer.
// READ_LATENCY is 2 when IMAGE_FRAME_BUFFER_OUTPUT_REG_EN is defined, otherwise 1.
package image_frame_buffer_pkg;
   typedef enum logic [2:0] {IDLE, FILL, COMMIT, PEND, SKIP} writer_state_t;
   function automatic int lane_ratio(input int write_width, input int read_width);
      return write_width / read_width;
   endfunction
`ifdef IMAGE_FRAME_BUFFER_OUTPUT_REG_EN
   localparam int READ_LATENCY = 2;
`else
   localparam int READ_LATENCY = 1;
`endif
endpackage

// File: rtl/image_frame_buffer_if.sv
// image_frame_buffer_if: camera write stream, frame control and lane read bus of the frame buffer.
interface image_frame_buffer_if
   import image_frame_buffer_pkg::*;
#(
   parameter int WRITE_WIDTH = 32,
   parameter int READ_WIDTH = 8,
   parameter int DEPTH_WORDS = 16384,
   parameter int WADDR_W = $clog2(DEPTH_WORDS),
   parameter int RADDR_W = WADDR_W + $clog2(lane_ratio(WRITE_WIDTH, READ_WIDTH))
);
   logic frame_start_in;
   logic frame_end_in;
   logic write_valid_in;
   logic [WRITE_WIDTH-1:0] write_data_in;
   logic read_lock_in;
   logic read_request_in;
   logic [RADDR_W-1:0] read_address_in;
   logic [READ_WIDTH-1:0] read_data_out;
   logic read_valid_out;
   logic frame_ready_out;
   logic [WADDR_W:0] frame_words_out;
   logic overflow_out;
   logic frame_dropped_out;
   modport master (
      output frame_start_in, frame_end_in, write_valid_in, write_data_in, read_lock_in, read_request_in, read_address_in,
      input read_data_out, read_valid_out, frame_ready_out, frame_words_out, overflow_out, frame_dropped_out
   );
   modport slave (
      input frame_start_in, frame_end_in, write_valid_in, write_data_in, read_lock_in, read_request_in, read_address_in,
      output read_data_out, read_valid_out, frame_ready_out, frame_words_out, overflow_out, frame_dropped_out
   );
endinterface

// File: rtl/image_frame_buffer_bank.sv
// image_frame_buffer_bank: single-port RAM bank whose port serves the writer or the reader by role.
// IMAGE_FRAME_BUFFER_OUTPUT_REG_EN adds an output register behind the RAM read.
module image_frame_buffer_bank #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16384,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input logic clock_in,
   input logic write_role,
   input logic write_enable,
   input logic [ADDR_W-1:0] write_address,
   input logic [WIDTH-1:0] write_data,
   input logic [ADDR_W-1:0] read_address,
   output logic [WIDTH-1:0] read_data
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] ram_q;
   logic [ADDR_W-1:0] address;
   assign address = write_role ? write_address : read_address;
   always_ff @(posedge clock_in) begin
      if (write_role && write_enable) mem[address] <= write_data;
      ram_q <= mem[address];
   end
`ifdef IMAGE_FRAME_BUFFER_OUTPUT_REG_EN
   always_ff @(posedge clock_in) read_data <= ram_q;
`else
   assign read_data = ram_q;
`endif
endmodule

// File: rtl/image_frame_buffer.sv
// image_frame_buffer: double-banked frame buffer; the camera fills one bank while lanes are read from the committed one.
// IMAGE_FRAME_BUFFER_OUTPUT_REG_EN raises read latency to 2 via a RAM output register.
module image_frame_buffer
   import image_frame_buffer_pkg::*;
#(
   parameter int WRITE_WIDTH = 32,
   parameter int READ_WIDTH = 8,
   parameter int DEPTH_WORDS = 16384,
   parameter int WADDR_W = $clog2(DEPTH_WORDS),
   parameter int RADDR_W = WADDR_W + $clog2(lane_ratio(WRITE_WIDTH, READ_WIDTH))
) (
   input logic clock_in,
   input logic reset_in,
   image_frame_buffer_if.slave bus
);
   localparam int RATIO = lane_ratio(WRITE_WIDTH, READ_WIDTH);
   localparam int LSB_W = $clog2(RATIO);
   localparam int LANE_W = LSB_W > 0 ? LSB_W : 1;
   localparam int PTR_W = WADDR_W + 1;
   writer_state_t state, state_next;
   logic write_bank, held_start, start, swap, begin_fill, restart, write_word, overflow_hit, drop;
   logic [PTR_W-1:0] pointer;
   logic [RADDR_W-1:0] read_address;
   logic [WADDR_W-1:0] word_address;
   logic [LANE_W-1:0] lane;
   logic [WRITE_WIDTH-1:0] bank_data [2];
   logic [WRITE_WIDTH-1:0] read_word;
   logic [READ_LATENCY-1:0] valid_pipe, ready_pipe, bank_pipe;
   logic [LANE_W-1:0] lane_pipe [READ_LATENCY];
   assign start = bus.frame_start_in || held_start;
   always_ff @(posedge clock_in)
      state <= reset_in ? IDLE : state_next;
   always_comb begin
      state_next = state;
      case (state)
         IDLE: state_next = start ? FILL : IDLE;
         FILL: state_next = bus.frame_end_in ? COMMIT : FILL;
         COMMIT: state_next = bus.read_lock_in ? PEND : start ? FILL : IDLE;
         PEND: state_next = !bus.read_lock_in ? (start ? FILL : IDLE) : start ? SKIP : PEND;
         SKIP: state_next = bus.frame_end_in ? PEND : SKIP;
         default: state_next = IDLE;
      endcase
   end
   always_comb begin
      swap = (state == COMMIT || state == PEND) && !bus.read_lock_in;
      begin_fill = state != FILL && state_next == FILL;
      restart = state == FILL && bus.frame_start_in && !bus.frame_end_in;
      write_word = state == FILL && bus.write_valid_in && !restart && !pointer[WADDR_W];
      overflow_hit = state == FILL && bus.write_valid_in && !restart && pointer[WADDR_W];
      drop = restart || (state == PEND && bus.read_lock_in && start) || (state == SKIP && bus.frame_start_in);
   end
   // A start that arrives with the end (or while committing under lock) is held until the commit resolves.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         write_bank <= 1'b0;
         held_start <= 1'b0;
         pointer <= '0;
         bus.overflow_out <= 1'b0;
         bus.frame_words_out <= '0;
         bus.frame_ready_out <= 1'b0;
         bus.frame_dropped_out <= 1'b0;
      end else begin
         write_bank <= write_bank ^ swap;
         held_start <= (bus.frame_start_in && ((state == FILL && bus.frame_end_in) || (state == COMMIT && bus.read_lock_in)))
                       || (held_start && !begin_fill && !(state == PEND && bus.read_lock_in));
         pointer <= (begin_fill || restart) ? '0 : pointer + PTR_W'(write_word);
         bus.overflow_out <= !(begin_fill || restart) && (bus.overflow_out || overflow_hit);
         bus.frame_words_out <= swap ? pointer : bus.frame_words_out;
         bus.frame_ready_out <= bus.frame_ready_out || swap;
         bus.frame_dropped_out <= drop;
      end
   end
   assign read_address = bus.read_address_in;
   assign word_address = WADDR_W'(read_address >> LSB_W);
   assign lane = LSB_W == 0 ? '0 : LANE_W'(read_address);
   for (genvar b = 0; b < 2; b++) begin : g_bank
      image_frame_buffer_bank #(.WIDTH(WRITE_WIDTH), .DEPTH(DEPTH_WORDS), .ADDR_W(WADDR_W)) u_bank (
         .clock_in,
         .write_role(write_bank == 1'(b)),
         .write_enable(write_word),
         .write_address(pointer[WADDR_W-1:0]),
         .write_data(bus.write_data_in),
         .read_address(word_address),
         .read_data(bank_data[b])
      );
   end
   // Bank, lane and ready travel with the RAM read so a swap cannot redirect an in-flight request.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         valid_pipe <= '0;
         ready_pipe <= '0;
         bank_pipe <= '0;
         lane_pipe <= '{default: '0};
      end else begin
         valid_pipe[0] <= bus.read_request_in;
         ready_pipe[0] <= bus.frame_ready_out;
         bank_pipe[0] <= !write_bank;
         lane_pipe[0] <= lane;
         for (int i = 1; i < READ_LATENCY; i++) begin
            valid_pipe[i] <= valid_pipe[i-1];
            ready_pipe[i] <= ready_pipe[i-1];
            bank_pipe[i] <= bank_pipe[i-1];
            lane_pipe[i] <= lane_pipe[i-1];
         end
      end
   end
   assign read_word = bank_data[bank_pipe[READ_LATENCY-1]];
   assign bus.read_valid_out = valid_pipe[READ_LATENCY-1];
   assign bus.read_data_out = (valid_pipe[READ_LATENCY-1] && ready_pipe[READ_LATENCY-1])
                              ? READ_WIDTH'(read_word >> (lane_pipe[READ_LATENCY-1] * READ_WIDTH)) : '0;
endmodule

// File: doc/image_frame_buffer.md
Name: image_frame_buffer

Overview:
- Parametrised double-banked successor to the camera image buffer.
- Streams WRITE_WIDTH-bit words from the camera pipeline into a write bank while the SPI/readout side fetches READ_WIDTH-bit lanes from the last committed frame in the other bank.
- Write and read run concurrently.
- Bank swap happens at frame end, with a reader lock and a dropped-frame report.

Parameters:
- WRITE_WIDTH, 32, width of a write word; must be an integer multiple of READ_WIDTH.
- READ_WIDTH, 8, width of a read lane.
- DEPTH_WORDS, 16384, words per bank; power of two.
- WADDR_W, $clog2(DEPTH_WORDS), derived write address width.
- RADDR_W, WADDR_W + $clog2(WRITE_WIDTH/READ_WIDTH), derived read address width.

Ports:
- clock_in  in  1  single clock for all logic.
- reset_in  in  1  synchronous, active-high reset.
- frame_start_in  in  1  pulse; begin filling the write bank at word 0.
- frame_end_in  in  1  pulse; commit the write bank.
- write_valid_in  in  1  write_data_in valid this cycle.
- write_data_in  in  WRITE_WIDTH  pixel word.
- read_lock_in  in  1  high = reader busy; defer bank swap.
- read_request_in  in  1  fetch one lane.
- read_address_in  in  RADDR_W  lane address in the committed frame.
- read_data_out  out  READ_WIDTH  fetched lane.
- read_valid_out  out  1  read_data_out valid.
- frame_ready_out  out  1  a committed frame is readable.
- frame_words_out  out  WADDR_W+1  word count of the committed frame.
- overflow_out  out  1  sticky; the current frame exceeded DEPTH_WORDS.
- frame_dropped_out  out  1  one-cycle pulse; a frame was discarded.

Behaviour:
- Reset:
  - All outputs are 0.
  - write_bank=0, read_bank=1, state=IDLE, pending_swap=0.
  - RAM contents are not cleared.
  - Reset mid-frame abandons the frame silently: no commit, no drop pulse.
- Writer FSM:
  - IDLE --frame_start--> FILL. Pointer=0, overflow_out=0.
  - FILL: each write_valid_in writes write_data_in to write_bank[pointer], then pointer+1.
  - At pointer==DEPTH_WORDS the write is discarded, pointer saturates and overflow_out=1.
  - FILL --frame_end--> COMMIT. Valid data in the same cycle is written and counted.
  - COMMIT, read_lock_in low: read_bank<=write_bank, write_bank toggles, frame_words_out<=pointer, frame_ready_out=1. Next state IDLE. Commit takes 1 cycle.
  - COMMIT, read_lock_in high: pending_swap=1, state PEND. Swap executes the first cycle after lock falls.
  - PEND + frame_start: pulse frame_dropped_out, state SKIP. All writes are ignored.
  - SKIP + frame_end: return to PEND. The pending frame is kept.
  - IDLE/COMMIT + frame_end without a start: ignored.
  - FILL + frame_start (restart): pulse frame_dropped_out, pointer=0.
- Simultaneous frame_end and frame_start in FILL:
  - End is processed first (commit or PEND).
  - Start is then applied on the next cycle; the writer registers it as a held start.
- Reader:
  - Lane address = read_address_in[RADDR_W-1:log2 ratio] selects the word in read_bank; the low bits select the lane (lane 0 = LSBs).
  - Lane-select bits are registered alongside the RAM read, so a lane can never be taken from a different request.
  - Latency is 1 cycle: read_valid_out is high the cycle after read_request_in.
  - Requests are accepted every cycle; there is no backpressure.
  - A request with frame_ready_out low returns read_valid_out=1 with data 0.
  - Addresses at or beyond frame_words_out return stale RAM contents; this is not flagged.
  - A swap in the same cycle as a request: the request reads the old read_bank.

Optional Feature:
- IMAGE_FRAME_BUFFER_OUTPUT_REG_EN:
  - Defined: adds a RAM output register, giving read latency 2. read_valid_out and the lane select are delayed to match; improves timing on LRAM.
  - Undefined: latency is 1 as above.

Decomposition:
- Package image_frame_buffer_pkg holds:
  - the writer state enum (IDLE, FILL, COMMIT, PEND, SKIP);
  - a lane-ratio localparam function;
  - a read latency constant keyed on the macro.
- Sub-module image_frame_buffer_bank: one inferred single-port WRITE_WIDTH x DEPTH_WORDS RAM, instantiated twice. Each bank's address is muxed between writer and reader according to the bank role.

Test Plan:
- Single frame:
  - Stimulus: start; write 0x03020100,0x07060504; end; lock low; read lanes 0..7.
  - Required: data 0x00..0x07 at latency 1; frame_words_out=2; frame_ready_out=1.
- Concurrent frames:
  - Stimulus: while reading frame A lane 5, fill frame B with 0xAAAAAAAA words.
  - Required: reads return A data until the B commit, then 0xAA.
- Lock and drop:
  - Stimulus: lock high; commit frame B.
  - Required: frame_ready stays on A.
  - Stimulus: start frame C.
  - Required: frame_dropped_out pulses once.
  - Stimulus: end C; drop lock.
  - Required: swap to B, never C.
- Overflow:
  - Stimulus: DEPTH_WORDS=16; write 20 words; end.
  - Required: overflow_out=1, frame_words_out=16, words 16-19 absent.
- Simultaneous events:
  - Stimulus: frame_end, frame_start and write_valid in the same cycle.
  - Required: the word is counted in the old frame; the new frame starts at 0 with 0 words.
- Reset:
  - Stimulus: reset mid-FILL at word 7.
  - Required: all outputs 0, no drop pulse; the next frame starts at word 0 in bank 0.
- Repeat all tests with IMAGE_FRAME_BUFFER_OUTPUT_REG_EN defined; required latency is 2.
